// File: rtl/icache_refill_axi_pkg.sv
// Shared cache package: refill FSM state encoding and AXI encodings.
package icache_refill_axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_RECV = 2'd2,
        ST_DONE = 2'd3
    } refill_state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/icache_refill_axi_line_buf.sv
// Cache line assembly buffer: one 32-bit word written per enable, full line visible.
module refill_line_buf #(
    parameter int LINE_WORDS = 16,
    parameter int IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [IDX_W-1:0]        idx,
    input  logic [31:0]             wdata,
    output logic [32*LINE_WORDS-1:0] line
);

    logic [LINE_WORDS-1:0][31:0] words;

    // Word storage; contents only change on a write, so the line holds between fills.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words <= '0;
        end else if (we) begin
            words[idx] <= wdata;
        end
    end

    assign line = words;

endmodule

// File: rtl/icache_refill_axi.sv
// I-cache line refill engine: one AXI INCR read burst per miss, assembled into a line.
module icache_refill_axi
    import icache_refill_axi_pkg::*;
#(
    parameter int LINE_WORDS = 16,
    parameter int ADDR_W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     r_req,
    input  logic [ADDR_W-1:0]        r_addr,
    input  logic                     r_data_ready,
    output logic                     r_rdy_AXI,
    output logic                     fill_finish,
    output logic [32*LINE_WORDS-1:0] fill_line,
    output logic                     fill_err,
    output logic [ADDR_W-1:0]        araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [31:0]              rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready
);

    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam int OFF_W = CNT_W + 2;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORDS - 1);

    refill_state_e     state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt;
    logic              err_q;
    logic              beat;
    logic              last_beat;
    logic              beat_bad;

    assign beat      = (state == ST_RECV) && rvalid && r_data_ready;
    assign last_beat = (cnt == LAST_IDX);
    // A beat is bad on an error response or when rlast disagrees with our own count.
    assign beat_bad  = (rresp != RESP_OKAY) || (rlast != last_beat);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs; all outputs decode from state so reset clears them at once.
    always_comb begin
        state_nxt   = state;
        arvalid     = 1'b0;
        r_rdy_AXI   = 1'b0;
        rready      = 1'b0;
        fill_finish = 1'b0;
        unique case (state)
            ST_IDLE: if (r_req) state_nxt = ST_AR;
            ST_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    r_rdy_AXI = 1'b1;
                    state_nxt = ST_RECV;
                end
            end
            ST_RECV: begin
                rready = r_data_ready;
                // Completion is by beat count; a wrong rlast is only flagged.
                if (beat && last_beat) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                fill_finish = 1'b1;
                state_nxt   = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request capture, beat counter and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
        end else if (state == ST_IDLE && r_req) begin
            addr_q <= {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            cnt    <= '0;
            err_q  <= 1'b0;
        end else if (beat) begin
            cnt <= cnt + 1'b1;
            if (beat_bad) err_q <= 1'b1;
        end
    end

    assign araddr   = addr_q;
    assign arlen    = 8'(LINE_WORDS - 1);
    assign arsize   = SIZE_4B;
    assign arburst  = BURST_INCR;
    assign fill_err = err_q;

    refill_line_buf #(
        .LINE_WORDS(LINE_WORDS),
        .IDX_W     (CNT_W)
    ) u_line_buf (
        .clk  (clk),
        .rst  (rst),
        .we   (beat),
        .idx  (cnt),
        .wdata(rdata),
        .line (fill_line)
    );

endmodule

// File: tb/tb_icache_refill_axi.sv
// Directed bench for icache_refill_axi with LINE_WORDS=16, ADDR_W=32.
module tb_icache_refill_axi;

    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          r_req;
    logic [31:0]   r_addr;
    logic          r_data_ready;
    logic          r_rdy_AXI;
    logic          fill_finish;
    logic [32*LW-1:0] fill_line;
    logic          fill_err;
    logic [31:0]   araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    icache_refill_axi #(.LINE_WORDS(LW), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .r_req(r_req), .r_addr(r_addr),
        .r_data_ready(r_data_ready), .r_rdy_AXI(r_rdy_AXI),
        .fill_finish(fill_finish), .fill_line(fill_line), .fill_err(fill_err),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic idle_inputs();
        r_req = 0; r_addr = 0; r_data_ready = 0; arready = 0;
        rdata = 0; rresp = 2'b00; rlast = 0; rvalid = 0;
    endtask

    // One full refill. bad_beat/last_beat give the beat index carrying rresp=SLVERR / rlast.
    task automatic run_fill(input logic [31:0] addr, input logic [31:0] exp_araddr,
                            input int ar_wait, input bit toggle, input int bad_beat,
                            input int last_beat, input bit exp_err, input int exp_lat,
                            input logic [31:0] seed);
        int k, cyc, lat, rr_pulses;
        bit rdy, ok;
        @(posedge clk); #1 r_req = 1; r_addr = addr;
        @(posedge clk); #1 r_req = 0; r_addr = 32'hFFFF_FFFF; lat = 1;
        rr_pulses = 0; ok = 1;
        for (int w = 0; w <= ar_wait; w++) begin
            arready = (w == ar_wait);
            @(negedge clk);
            if (arvalid !== 1'b1 || araddr !== exp_araddr || rready !== 1'b0) ok = 0;
            if (r_rdy_AXI === 1'b1) begin
                rr_pulses++;
                if (w != ar_wait) ok = 0;
            end
            @(posedge clk); #1 lat++;
        end
        arready = 0;
        chk("ar_phase", {31'd0, ok}, 32'd1);
        chk("rdy_axi_pulses", rr_pulses, 1);
        chk("arlen", {24'd0, arlen}, 32'd15);
        chk("arsize_arburst", {27'd0, arsize, arburst}, {27'd0, 3'b010, 2'b01});
        k = 0; cyc = 0; ok = 1;
        while (k < LW && cyc < 200) begin
            rdy = toggle ? (cyc % 2 == 0) : 1'b1;
            r_data_ready = rdy; rvalid = 1;
            rdata = seed + k;
            rresp = (k == bad_beat) ? 2'b10 : 2'b00;
            rlast = (k == last_beat);
            r_req = (cyc == 5);
            @(negedge clk);
            if (rready !== rdy || arvalid !== 1'b0 || fill_finish !== 1'b0) ok = 0;
            @(posedge clk); #1
            if (rdy) k++;
            cyc++; lat++;
        end
        chk("recv_phase", {31'd0, ok}, 32'd1);
        chk("beats_done", k, LW);
        idle_inputs();
        @(negedge clk);
        chk("fill_finish", {31'd0, fill_finish}, 32'd1);
        chk("fill_err", {31'd0, fill_err}, {31'd0, exp_err});
        chk("latency", lat, exp_lat);
        chk("araddr_hold", araddr, exp_araddr);
        ok = 1;
        for (int i = 0; i < LW; i++)
            if (fill_line[i*32 +: 32] !== seed + i) ok = 0;
        chk("line_words", {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("finish_one_cycle", {31'd0, fill_finish}, 32'd0);
        chk("back_idle", {30'd0, arvalid, rready}, 32'd0);
        chk("line_stable", fill_line[5*32 +: 32], seed + 5);
    endtask

    initial begin
        int pulses;
        idle_inputs();
        rst = 1;
        #12;
        chk("rst_outs", {26'd0, arvalid, rready, r_rdy_AXI, fill_finish, fill_err, 1'b0}, 32'd0);
        chk("rst_line", {31'd0, (fill_line == '0)}, 32'd1);
        @(posedge clk); #1 rst = 0;

        // Basic fill, zero wait states, rlast on beat 15.
        run_fill(32'h1C00_0047, 32'h1C00_0040, 0, 0, -1, 15, 0, 18, 32'h0);
        // AR held off 5 cycles.
        run_fill(32'h2000_107F, 32'h2000_1040, 5, 0, -1, 15, 0, 23, 32'hA000_0000);
        // r_data_ready toggling: 16 beats over 31 cycles.
        run_fill(32'h0000_0FC4, 32'h0000_0FC0, 0, 1, -1, 15, 0, 33, 32'h5500_0100);
        // SLVERR on beat 3, then a clean fill clears the flag.
        run_fill(32'h3000_0000, 32'h3000_0000, 0, 0, 3, 15, 1, 18, 32'h1111_0000);
        run_fill(32'h3000_0040, 32'h3000_0040, 0, 0, -1, 15, 0, 18, 32'h2222_0000);
        // Early rlast on beat 10 (index 9): still 16 beats, error flagged.
        run_fill(32'h4000_0080, 32'h4000_0080, 0, 0, -1, 9, 1, 18, 32'h3333_0000);

        // Reset after 7 accepted beats.
        @(posedge clk); #1 r_req = 1; r_addr = 32'h5000_0000;
        @(posedge clk); #1 r_req = 0; arready = 1;
        @(posedge clk); #1 arready = 0;
        for (int k = 0; k < 7; k++) begin
            r_data_ready = 1; rvalid = 1; rdata = 32'hDEAD_0000 + k;
            @(posedge clk); #1;
        end
        #2 rst = 1;
        #1;
        chk("midrst_outs", {27'd0, arvalid, rready, r_rdy_AXI, fill_finish, fill_err}, 32'd0);
        chk("midrst_line", {31'd0, (fill_line == '0)}, 32'd1);
        chk("midrst_araddr", araddr, 32'd0);
        @(posedge clk); #1 rst = 0;
        pulses = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (fill_finish === 1'b1 || rready === 1'b1) pulses++;
        end
        chk("no_finish_after_rst", pulses, 0);
        idle_inputs();
        run_fill(32'h6000_00C8, 32'h6000_00C0, 0, 0, -1, 15, 0, 18, 32'h7777_0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/icache_refill_axi.md
ICACHE_REFILL_AXI -- requirements
Module: icache_refill_axi

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 16, 32-bit words per cache line (power of two, 2..16).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have port clk  input  1  single clock; all state rises on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port r_req  input  1  refill request from I-cache main FSM.
REQ-006 SHALL have port r_addr  input  ADDR_W  miss address, sampled with r_req.
REQ-007 SHALL have port r_data_ready  input  1  FSM is in REFILL and accepts beats.
REQ-008 SHALL have port r_rdy_AXI  output  1  one-cycle pulse: AR handshake completed.
REQ-009 SHALL have port fill_finish  output  1  one-cycle pulse: full line valid on fill_line.
REQ-010 SHALL have port fill_line  output  32*LINE_WORDS  assembled line, word 0 in bits [31:0].
REQ-011 SHALL have port fill_err  output  1  valid with fill_finish: bad rresp or rlast mismatch in this fill.
REQ-012 SHALL have AXI AR ports: araddr ADDR_W out, arlen 8 out, arsize 3 out, arburst 2 out, arvalid 1 out, arready 1 in.
REQ-013 SHALL have AXI R ports: rdata 32 in, rresp 2 in, rlast 1 in, rvalid 1 in, rready 1 out.

Function
REQ-014 SHALL implement states IDLE, AR, RECV, DONE.
REQ-015 IDLE: on r_req=1, latch r_addr with low log2(LINE_WORDS)+2 bits zeroed, clear beat counter and error flag, go AR next cycle.
REQ-016 AR: arvalid=1, araddr=latched aligned address; arlen=LINE_WORDS-1, arsize=3'b010, arburst=2'b01 (INCR), constant throughout.
REQ-017 AR: on arvalid&&arready, r_rdy_AXI=1 in that same cycle (combinational from state and arready), go RECV; arvalid never deasserted before handshake.
REQ-018 RECV: rready = r_data_ready; beat accepted when rvalid&&rready; word stored at index = beat counter; counter increments by 1.
REQ-019 RECV: on accepted beat with counter = LINE_WORDS-1, go DONE regardless of rlast.
REQ-020 fill_err SHALL set on any accepted beat with rresp != 2'b00, rlast=1 with counter < LINE_WORDS-1, or rlast=0 on the final beat; sticky until next IDLE acceptance.
REQ-021 DONE: fill_finish=1 for exactly one cycle, fill_err valid, go IDLE; fill_line SHALL hold stable from DONE until the next accepted r_req.
REQ-022 r_req while not IDLE SHALL be ignored; r_req in the DONE cycle is not captured (accepted earliest one cycle later, in IDLE).
REQ-023 rready SHALL be 0 in IDLE, AR, DONE; arvalid SHALL be 0 outside AR.
REQ-024 Latency with arready and rvalid tied high and r_data_ready=1: r_req cycle T -> AR at T+1 -> first beat at T+2 -> fill_finish at T+2+LINE_WORDS.

Reset
REQ-025 rst SHALL immediately force state IDLE, counter 0, fill_err 0, arvalid 0, rready 0, r_rdy_AXI 0, fill_finish 0, fill_line all zero.
REQ-026 Reset mid-burst SHALL abandon the transaction; no fill_finish is produced for it.

Structure
REQ-027 AXI constants (BURST_INCR, SIZE_4B, RESP_OKAY) and the state encoding SHALL reside in the shared cache package.
REQ-028 Line storage SHALL be a sub-module refill_line_buf (write-enable, word index, word in, full line out).

Verification
REQ-029 LINE_WORDS=16, r_addr=0x1C00_0047, arready=1, rdata=beat index, rlast on 16th -> araddr=0x1C00_0040, arlen=15, fill_finish at T+18, fill_line word k=k, fill_err=0.
REQ-030 arready held low 5 cycles -> arvalid stays 1, araddr stable, r_rdy_AXI pulses once on cycle 6 only.
REQ-031 r_data_ready toggled 1/0 every cycle -> rready follows, exactly 16 beats stored in order, single fill_finish.
REQ-032 rresp=2'b10 on beat 3 -> fill completes, fill_err=1 with fill_finish; next clean fill reports fill_err=0.
REQ-033 rlast asserted on beat 10 -> fill_err=1, completion still after beat 16.
REQ-034 rst asserted after beat 7 -> all outputs zero asynchronously, no fill_finish; new r_req after release completes normally.
